uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that sits directly downstream of the team's UART transmitter and turns its line back into bytes. It accepts frames of one start bit (0), 8 data bits LSB first, an optional even-parity bit, and one stop bit (1). It presents each byte on a valid/ready interface with one holding register. It flags parity, framing and overrun errors.

## Interface
- CLKS_PER_BIT, 1: clock cycles per bit on the line; must be ≥1; 1 matches the transmitter's one-bit-per-clock output.
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- rx_in  input  1  serial line; idles high.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  holding register contains an unread byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- parity_err  output  1  parity mismatch on the byte currently held; meaningful only while rx_valid=1.
- frame_err  output  1  one-cycle pulse: the stop bit was sampled as 0.
- overrun_err  output  1  one-cycle pulse: a good frame completed while the holding register was full.

## Operation
- Input passes a 2-flop synchronizer with both flops resetting to 1. All references below are to the synchronized line, `rxs`.
- Bit counter: 3 bits. Cycle counter: $clog2(CLKS_PER_BIT)+1 bits. HALF = (CLKS_PER_BIT-1)/2, integer division.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE → START on the first cycle `rxs`=0. The cycle counter loads HALF.
- START: when the counter reaches 0, sample `rxs`.
  - `rxs`=0: go to DATA, counter = CLKS_PER_BIT-1.
  - `rxs`=1: false start; go to IDLE with no flags.
- DATA: sample one bit every CLKS_PER_BIT cycles. Each bit shifts into bit 7 of the shift register, shifting right. The running XOR of the bits is accumulated.
  - After the 8th bit, go to PARITY if parity is compiled in, else STOP.
- PARITY: sample one bit. parity_bad = sampled bit XOR running XOR. Even parity: the parity bit is 1 when the data contains an odd number of ones. → STOP.
- STOP: sample one bit.
  - Stop bit = 1 and holding register empty, or being emptied this same cycle (rx_valid & rx_ready): load rx_data and parity_err, set rx_valid, go to IDLE.
  - Stop bit = 1 and holding register full, not being emptied: pulse overrun_err, drop the new byte, keep the held byte, go to IDLE.
  - Stop bit = 0: pulse frame_err, drop the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rxs`=1, then go to IDLE. A break condition therefore never produces repeated frames.
- Holding register: rx_valid clears on the handshake cycle unless a new byte loads in that same cycle, in which case it stays 1.
- Reset (asynchronous, any time including mid-frame): FSM → IDLE, counters 0, shift register 0. Outputs: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0.

## Timing
- Sample point k sits HALF + k·CLKS_PER_BIT cycles after the IDLE→START cycle.
  - k=0: start bit.
  - k=1..8: data bits.
  - k=9: parity bit, if compiled in.
  - Last k: stop bit.
- rx_valid, frame_err and overrun_err register on the cycle after the stop sample.
- Back-to-back frames: the next start bit may immediately follow the stop bit. After the stop sample, the FSM is in IDLE on the next cycle, so there is no dead time.
- CLKS_PER_BIT=1 latency: the frame's start bit first at rx_in to rx_valid=1 takes 2 (sync) + 1 + 10 (or 9 without parity) + 1 cycles.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is 11 bits and the PARITY state is present.
  - parity_err reports the held byte's parity status.
- UART_RX_PARITY_EN undefined:
  - Frame is 10 bits and the PARITY state is omitted.
  - parity_err is tied to 0.
  - The transmitter must be configured to match.

## Test plan
- Parity on, CLKS_PER_BIT=1: line 0,1,0,1,0,0,1,0,1,0,1 (0xA5 LSB first, parity 0, stop) → rx_data=0xA5, rx_valid=1, parity_err=0.
- Same frame with the parity bit flipped to 1 → rx_data=0xA5, rx_valid=1, parity_err=1.
- Frame 0x3C with stop bit 0, then line held low for 20 cycles, then high → exactly one frame_err pulse and rx_valid stays 0. A following good frame 0x01 is received correctly.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data stays 0x11 and overrun_err pulses once. Raising rx_ready then drains 0x11, and rx_valid=0.
- CLKS_PER_BIT=16: a 1-cycle low glitch while the line is otherwise high → no output. A full 0x5A frame at 16 cycles/bit → rx_data=0x5A.
- Assert rst mid-frame (at the 4th data bit), then send frame 0xFF → all outputs 0 during reset. After release, only 0xFF is delivered, with parity_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: serial receiver (start, 8 data bits LSB first, optional even parity, stop)
// with a single-entry valid/ready holding register and parity/framing/overrun flags.
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity bit and parity_err).
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int unsigned CW      = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned HALF    = (CLKS_PER_BIT - 1) / 2;
    // START is entered one cycle after the start bit is detected, so it waits HALF-1 more.
    localparam int unsigned HALF_M1 = (HALF == 0) ? 0 : HALF - 1;
    localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] START_LOAD = CW'(HALF_M1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    logic          sync1_q, sync2_q;
    logic          rxs;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_err_q, overrun_err_d;
    logic          cnt_zero;
`ifdef UART_RX_PARITY_EN
    logic          par_acc_q, par_acc_d;
    logic          parity_bad_q, parity_bad_d;
    logic          parity_err_q, parity_err_d;
`endif

    assign rxs      = sync2_q;
    assign cnt_zero = (cnt_q == '0);

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, bit timing, shift register and holding-register update.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~rx_ready;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_acc_d     = par_acc_q;
        parity_bad_d  = parity_bad_q;
        parity_err_d  = parity_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    bit_cnt_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_acc_d = 1'b0;
`endif
                    // With HALF=0 the detection cycle is itself the start-bit sample.
                    if (HALF == 0) begin
                        state_d = S_DATA;
                        cnt_d   = BIT_RELOAD;
                    end else begin
                        state_d = S_START;
                        cnt_d   = START_LOAD;
                    end
                end
            end
            S_START: begin
                if (cnt_zero) begin
                    if (!rxs) begin
                        state_d = S_DATA;
                        cnt_d   = BIT_RELOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    shift_d   = {rxs, shift_q[7:1]};
                    cnt_d     = BIT_RELOAD;
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    par_acc_d = par_acc_q ^ rxs;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_cnt_q == 3'd7) state_d = S_STOP;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_zero) begin
                    parity_bad_d = rxs ^ par_acc_q;
                    cnt_d        = BIT_RELOAD;
                    state_d      = S_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d    = shift_q;
                            rx_valid_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = parity_bad_q;
`endif
                        end else begin
                            overrun_err_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rxs) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity accumulator, per-frame parity result and the held byte's parity flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_acc_q    <= 1'b0;
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_acc_q    <= par_acc_d;
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (1 and 16 clocks per bit), frame-level reference
// model feeding per-instance scoreboards; a monitor pops on every handshake.
module tb_uart_rx;

    localparam int unsigned CPB_SLOW = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       line0, line1, rdy0, rdy1;
    logic [7:0] data0, data1;
    logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

    uart_rx #(.CLKS_PER_BIT(1)) u_fast (
        .clk(clk), .rst(rst), .rx_in(line0), .rx_data(data0), .rx_valid(v0),
        .rx_ready(rdy0), .parity_err(pe0), .frame_err(fe0), .overrun_err(ov0)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_SLOW)) u_slow (
        .clk(clk), .rst(rst), .rx_in(line1), .rx_data(data1), .rx_valid(v1),
        .rx_ready(rdy1), .parity_err(pe1), .frame_err(fe1), .overrun_err(ov1)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    int         exp_fe[2];
    int         exp_ov[2];
    int         seen_fe[2];
    int         seen_ov[2];
    bit         full[2];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pop and compare on every handshake, count error pulses.
    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (rst) begin
            if (v0 && rdy0) begin
                chk("fast_byte_expected", 32'(exp_q0.size() != 0), 32'd1);
                if (exp_q0.size() != 0) begin
                    e = exp_q0.pop_front();
                    chk("fast_rx_data", 32'(data0), 32'(e[7:0]));
                    chk("fast_parity_err", 32'(pe0), 32'(e[8]));
                end
            end
            if (v1 && rdy1) begin
                chk("slow_byte_expected", 32'(exp_q1.size() != 0), 32'd1);
                if (exp_q1.size() != 0) begin
                    e = exp_q1.pop_front();
                    chk("slow_rx_data", 32'(data1), 32'(e[7:0]));
                    chk("slow_parity_err", 32'(pe1), 32'(e[8]));
                end
            end
            if (fe0) seen_fe[0]++;
            if (fe1) seen_fe[1]++;
            if (ov0) seen_ov[0]++;
            if (ov1) seen_ov[1]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int which, input logic b);
        if (which == 0) begin
            line0 = b;
            tick(1);
        end else begin
            line1 = b;
            tick(CPB_SLOW);
        end
    endtask

    task automatic idle_bits(input int which, input int n);
        for (int i = 0; i < n; i++) drive(which, 1'b1);
    endtask

    // Model a whole frame's outcome, then put it on the line.
    task automatic send_frame(input int which, input logic [7:0] d, input bit flip, input bit stop);
        logic [8:0] item;
        logic       rdy;
        rdy  = (which == 0) ? rdy0 : rdy1;
        item = {PAR & flip, d};
        if (!stop) begin
            exp_fe[which]++;
        end else if (full[which]) begin
            exp_ov[which]++;
        end else begin
            if (which == 0) exp_q0.push_back(item);
            else            exp_q1.push_back(item);
            if (!rdy) full[which] = 1'b1;
        end
        drive(which, 1'b0);
        for (int i = 0; i < 8; i++) drive(which, d[i]);
        if (PAR) drive(which, (^d) ^ flip);
        drive(which, stop);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] d;
        bit         st;
        rst   = 1'b0;
        line0 = 1'b1;
        line1 = 1'b1;
        rdy0  = 1'b1;
        rdy1  = 1'b1;
        tick(3);
        chk("reset_outs_fast", 32'({data0, v0, pe0, fe0, ov0}), 32'd0);
        chk("reset_outs_slow", 32'({data1, v1, pe1, fe1, ov1}), 32'd0);
        rst = 1'b1;
        tick(3);

        // Good frame, then the same frame with its parity bit inverted.
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        idle_bits(0, 4);
        send_frame(0, 8'hA5, 1'b1, 1'b1);
        idle_bits(0, 4);

        // Bad stop bit followed by a long break, then a good frame.
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        line0 = 1'b0;
        tick(20);
        idle_bits(0, 4);
        chk("break_frame_err_pulses", 32'(seen_fe[0]), 32'(exp_fe[0]));
        chk("break_no_valid", 32'(v0), 32'd0);
        send_frame(0, 8'h01, 1'b0, 1'b1);
        idle_bits(0, 4);

        // Overrun: consumer stalled across two back-to-back frames.
        rdy0 = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        idle_bits(0, 6);
        chk("ovr_held_data", 32'(data0), 32'h11);
        chk("ovr_held_valid", 32'(v0), 32'd1);
        chk("ovr_pulses", 32'(seen_ov[0]), 32'(exp_ov[0]));
        rdy0    = 1'b1;
        full[0] = 1'b0;
        tick(2);
        chk("drain_valid", 32'(v0), 32'd0);

        // Reset during the 4th data bit of a frame that must never appear.
        d = 8'hC3;
        drive(0, 1'b0);
        for (int i = 0; i < 3; i++) drive(0, d[i]);
        line0 = d[3];
        rst   = 1'b0;
        tick(2);
        chk("midreset_outs_fast", 32'({data0, v0, pe0, fe0, ov0}), 32'd0);
        chk("midreset_outs_slow", 32'({data1, v1, pe1, fe1, ov1}), 32'd0);
        line0 = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(3);
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        idle_bits(0, 4);

        // Randomized frames at one clock per bit, including parity and stop faults.
        for (int n = 0; n < 60; n++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 9) != 0);
            send_frame(0, d, ($urandom_range(0, 4) == 0), st);
            idle_bits(0, st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3)));
        end

        // Slow instance: single-cycle glitch must be rejected as a false start.
        line1 = 1'b0;
        tick(1);
        line1 = 1'b1;
        idle_bits(1, 3);
        chk("glitch_no_valid", 32'(v1), 32'd0);
        chk("glitch_no_frame_err", 32'(seen_fe[1]), 32'(exp_fe[1]));
        send_frame(1, 8'h5A, 1'b0, 1'b1);
        idle_bits(1, 2);
        for (int n = 0; n < 6; n++) begin
            send_frame(1, 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
            idle_bits(1, int'($urandom_range(0, 2)));
        end
        idle_bits(1, 2);

        for (int i = 0; i < 400 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) tick(1);
        chk("fast_queue_drained", 32'(exp_q0.size()), 32'd0);
        chk("slow_queue_drained", 32'(exp_q1.size()), 32'd0);
        chk("fast_frame_err_total", 32'(seen_fe[0]), 32'(exp_fe[0]));
        chk("fast_overrun_total", 32'(seen_ov[0]), 32'(exp_ov[0]));
        chk("slow_frame_err_total", 32'(seen_fe[1]), 32'(exp_fe[1]));
        chk("slow_overrun_total", 32'(seen_ov[1]), 32'(exp_ov[1]));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
